// File: rtl/aca_err_recovery.sv
// ---------------------------------------------------------------------------
// aca_err_recovery
//
// Error detection and recovery stage placed after the 16-bit ACA-CSU
// approximate adder. Each accepted transaction is screened with the
// block-propagate windows whose carry the CSU selects speculatively.
// Unflagged transactions forward the approximate sum after one cycle.
// Flagged transactions are recomputed exactly with one BLK-wide ripple step
// per cycle. The result is then presented until the consumer takes it.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   in_valid/ready  upstream handshake (ready only while IDLE)
//   a, b            WIDTH-bit unsigned operands
//   approx_sum      WIDTH+1-bit approximate sum for a + b
//   out_valid/ready downstream handshake
//   sum             WIDTH+1-bit final sum (approximate or corrected)
//   err_flag        high when the presented sum went through correction
//   err_cnt         saturating count of corrected transactions
//                   (present only when ACA_ERR_CNT_EN is defined)
//
// Optional feature macro: ACA_ERR_CNT_EN
// ---------------------------------------------------------------------------
module aca_err_recovery #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH:0]   approx_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             err_flag
`ifdef ACA_ERR_CNT_EN
   ,output logic [15:0]      err_cnt
`endif
);

    localparam int NBLK = WIDTH / BLK;
    localparam int IDXW = $clog2(NBLK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORR = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_p0, b_p0;
    logic [WIDTH:0]    sum_q;
    logic              err_q;
    logic [IDXW-1:0]   blk_idx;
    logic              carry;
    logic              accept;
    logic              flag;
    logic              last_blk;
    int                blk_base;
    logic [BLK:0]      blk_res;

    // Only the interior windows (blocks 1..NBLK-2) feed a speculated carry
    // in the CSU; the lowest block has no speculation and the top block's
    // propagate never selects a downstream carry.
    function automatic logic detect_err(input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] p;
        logic             f;
        p = x ^ y;
        f = 1'b0;
        for (int j = 1; j <= NBLK - 2; j++) begin
            f = f | (&p[j*BLK +: BLK]);
        end
        return f;
    endfunction

    function automatic logic [BLK:0] blk_add(input logic [BLK-1:0] x,
                                             input logic [BLK-1:0] y,
                                             input logic           ci);
        return {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, ci};
    endfunction

    assign accept   = in_valid && (state == IDLE);
    assign flag     = detect_err(a, b);
    assign last_blk = (blk_idx == IDXW'(NBLK - 1));
    assign blk_base = int'(blk_idx) * BLK;
    assign blk_res  = blk_add(a_p0[blk_base +: BLK], b_p0[blk_base +: BLK], carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = flag ? CORR : OUT;
                end
            end
            CORR: begin
                if (last_blk) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: capture operands at accept, then ripple one block per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0    <= '0;
            b_p0    <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            blk_idx <= '0;
            carry   <= 1'b0;
        end else if (accept) begin
            a_p0    <= a;
            b_p0    <= b;
            sum_q   <= approx_sum;
            err_q   <= 1'b0;
            blk_idx <= '0;
            carry   <= 1'b0;
        end else if (state == CORR) begin
            sum_q[blk_base +: BLK] <= blk_res[BLK-1:0];
            carry                  <= blk_res[BLK];
            blk_idx                <= blk_idx + 1'b1;
            if (last_blk) begin
                sum_q[WIDTH] <= blk_res[BLK];
                err_q        <= 1'b1;
            end
        end
    end

    assign sum      = sum_q;
    assign err_flag = err_q;

`ifdef ACA_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if ((state == OUT) && out_ready && err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
